// File: rtl/clock_pkg.sv
// Shared constants for the clock display path: active-low segment patterns
// (bit order g,f,e,d,c,b,a), digit slot indices and set-field encodings.
package clock_pkg;

    // Active-low segment patterns, seg[6:0] = g,f,e,d,c,b,a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit slot indices, matching the anode bit each one drives
    localparam logic [2:0] DIG_SEC_U  = 3'd0;
    localparam logic [2:0] DIG_SEC_T  = 3'd1;
    localparam logic [2:0] DIG_MIN_U  = 3'd2;
    localparam logic [2:0] DIG_MIN_T  = 3'd3;
    localparam logic [2:0] DIG_HOUR_U = 3'd4;
    localparam logic [2:0] DIG_HOUR_T = 3'd5;

    // Field currently being adjusted by the user
    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_HOUR = 2'b01,
        SEL_MIN  = 2'b10,
        SEL_SEC  = 2'b11
    } sel_e;

    // Which adjustable field a given digit slot belongs to
    function automatic sel_e digitField(input logic [2:0] idx);
        case (idx)
            DIG_SEC_U, DIG_SEC_T:   digitField = SEL_SEC;
            DIG_MIN_U, DIG_MIN_T:   digitField = SEL_MIN;
            DIG_HOUR_U, DIG_HOUR_T: digitField = SEL_HOUR;
            default:                digitField = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan6_bcd7seg.sv
// bcd7seg: combinational BCD to active-low seven-segment decoder.
// Non-decimal codes (10..15) light nothing.
module bcd7seg
    import clock_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup of the segment pattern for one BCD digit
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan6.sv
// seg_scan6: six-digit multiplexed seven-segment driver for the clock.
// Scans sec/min/hour BCD digits onto one shared active-low segment bus,
// shows PM on the hour-units decimal point and blanks a leading hour zero.
// Optional feature macro SEG_BLINK_EN: blinks the field selected by setSel.
module seg_scan6
    import clock_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_HALF = 83
) (
    input  logic       CP,
    input  logic       reset,
    input  logic [5:0] hour,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    input  logic       noon,
    input  logic [1:0] setSel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic          slotTick;
    logic          frameEnd;
    logic [3:0]    digitVal;
    logic [6:0]    segDec;
    logic          blankField;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    // Prescaler and digit index: one slot per SCAN_DIV cycles, six slots per frame
    always_comb begin
        slotTick = (presc_q == PW'(SCAN_DIV - 1));
        frameEnd = slotTick && (idx_q == DIG_HOUR_T);
        presc_d  = slotTick ? '0 : presc_q + 1'b1;
        idx_d    = idx_q;
        if (slotTick) begin
            idx_d = frameEnd ? DIG_SEC_U : idx_q + 3'd1;
        end
    end

    // Scan counters
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= DIG_SEC_U;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Pick the BCD nibble for the slot currently being scanned
    always_comb begin
        digitVal = 4'd0;
        case (idx_q)
            DIG_SEC_U:  digitVal = sec[3:0];
            DIG_SEC_T:  digitVal = {1'b0, sec[6:4]};
            DIG_MIN_U:  digitVal = min[3:0];
            DIG_MIN_T:  digitVal = {1'b0, min[6:4]};
            DIG_HOUR_U: digitVal = hour[3:0];
            DIG_HOUR_T: digitVal = {2'b00, hour[5:4]};
            default:    digitVal = 4'd0;
        endcase
    end

    bcd7seg u_dec (
        .bcd_i (digitVal),
        .seg_o (segDec)
    );

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;

    // Count whole frames and flip the blink phase every BLINK_HALF frames
    always_comb begin
        frame_d = frame_q;
        phase_d = phase_q;
        if (frameEnd) begin
            if (frame_q == FW'(BLINK_HALF - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Blink counters; phase 0 is the visible half
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign blankField = phase_q && (setSel != SEL_NONE) &&
                        (setSel == digitField(idx_q));
`else
    logic unusedSetSel;
    assign unusedSetSel = ^setSel;
    assign blankField   = 1'b0;
`endif

    // Next anode/segment/dp values: one anode low, suppressed for a leading
    // hour zero or a blinked-off field; dp marks PM on hour units
    always_comb begin
        an_d  = ~(6'b000001 << idx_q);
        seg_d = segDec;
        dp_d  = 1'b1;
        if (((idx_q == DIG_HOUR_T) && (hour[5:4] == 2'b00)) || blankField) begin
            an_d = 6'b111111;
        end
        if ((idx_q == DIG_HOUR_U) && noon && !blankField) begin
            dp_d = 1'b0;
        end
    end

    // Output registers keep the pad drivers glitch-free
    always_ff @(posedge CP or posedge reset) begin
        if (reset) begin
            an_q  <= 6'b111111;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg_scan6.sv
// tb_seg_scan6: scoreboard bench for seg_scan6 with SCAN_DIV=4, BLINK_HALF=2.
// Expectations for blinking depend on whether SEG_BLINK_EN is defined.
module tb_seg_scan6;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S3  = 7'b0110000;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] SBL = 7'b1111111;

    typedef struct {
        int         cyc;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       CP = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] hour;
    logic [6:0] min;
    logic [6:0] sec;
    logic       noon;
    logic [1:0] setSel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t sbq[$];
    int   cyc    = 0;
    int   base   = 0;
    int   checks = 0;
    int   errors = 0;

    seg_scan6 #(
        .SCAN_DIV   (4),
        .BLINK_HALF (2)
    ) dut (
        .CP     (CP),
        .reset  (reset),
        .hour   (hour),
        .min    (min),
        .sec    (sec),
        .noon   (noon),
        .setSel (setSel),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    // Free-running clock, period 10
    always #5 CP = ~CP;

    // Count rising edges so expectations can be tied to a specific update
    always @(posedge CP) cyc <= cyc + 1;

    // Queue an expected output for the e-th rising edge after base
    task automatic expectAt(input int e, input logic [5:0] a, input logic [6:0] s, input logic d);
        exp_t x;
        x.cyc = base + e;
        x.an  = a;
        x.seg = s;
        x.dp  = d;
        sbq.push_back(x);
    endtask

    task automatic applyStimulus(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s,
                                 input logic n, input logic [1:0] sel);
        hour   = h;
        min    = m;
        sec    = s;
        noon   = n;
        setSel = sel;
    endtask

    // Advance n cycles, landing just after a falling edge
    task automatic waitEdges(input int n);
        repeat (n) @(negedge CP);
        #2;
    endtask

    task automatic checkOutput(input exp_t x);
        checks++;
        if (x.cyc != cyc) begin
            errors++;
            $display("[TB] FAIL missed@cyc%0d: monitor reached cyc%0d first", x.cyc, cyc);
        end else if (an !== x.an || seg !== x.seg || dp !== x.dp) begin
            errors++;
            $display("[TB] FAIL slot@cyc%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     cyc, an, seg, dp, x.an, x.seg, x.dp);
        end
    endtask

    // Monitor: on each falling edge compare every expectation due this cycle
    always @(negedge CP) begin : monitor
        exp_t x;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            x = sbq.pop_front();
            checkOutput(x);
        end
    end

    initial begin
        applyStimulus(6'h23, 7'h45, 7'h07, 1'b0, 2'b00);
        base = 0;
        expectAt(1, 6'b111111, SBL, 1'b1);
        expectAt(2, 6'b111111, SBL, 1'b1);
        waitEdges(2);
        reset = 1'b0;
        base  = cyc;

        // Frame 0: 23:45:07, every digit shown, wrap at edge 25
        expectAt(1,  6'b111110, S7, 1'b1);
        expectAt(4,  6'b111110, S7, 1'b1);
        expectAt(5,  6'b111101, S0, 1'b1);
        expectAt(9,  6'b111011, S5, 1'b1);
        expectAt(13, 6'b110111, S4, 1'b1);
        expectAt(17, 6'b101111, S3, 1'b1);
        expectAt(21, 6'b011111, S2, 1'b1);
        expectAt(24, 6'b011111, S2, 1'b1);
        expectAt(25, 6'b111110, S7, 1'b1);
        waitEdges(24);

        // Frame 1: leading hour zero, PM dot, non-decimal minute units
        applyStimulus(6'h05, 7'h4C, 7'h07, 1'b1, 2'b10);
        expectAt(29, 6'b111101, S0,  1'b1);
        expectAt(33, 6'b111011, SBL, 1'b1);
        expectAt(37, 6'b110111, S4,  1'b1);
        expectAt(41, 6'b101111, S5,  1'b0);
        expectAt(45, 6'b111111, S0,  1'b1);
        waitEdges(20);

        // Frame 2: blink phase off, minutes selected
        applyStimulus(6'h05, 7'h45, 7'h07, 1'b1, 2'b10);
        expectAt(49, 6'b111110, S7, 1'b1);
        expectAt(53, 6'b111101, S0, 1'b1);
`ifdef SEG_BLINK_EN
        expectAt(57, 6'b111111, S5, 1'b1);
        expectAt(61, 6'b111111, S4, 1'b1);
`else
        expectAt(57, 6'b111011, S5, 1'b1);
        expectAt(61, 6'b110111, S4, 1'b1);
`endif
        waitEdges(20);

        // Switch to hour selection mid-frame: hour units and its dot go dark
        applyStimulus(6'h05, 7'h45, 7'h07, 1'b1, 2'b01);
`ifdef SEG_BLINK_EN
        expectAt(65, 6'b111111, S5, 1'b1);
`else
        expectAt(65, 6'b101111, S5, 1'b0);
`endif
        expectAt(69, 6'b111111, S0, 1'b1);
        waitEdges(4);

        // Seconds selected: off through frame 3, visible again in frame 4
        applyStimulus(6'h05, 7'h45, 7'h07, 1'b1, 2'b11);
`ifdef SEG_BLINK_EN
        expectAt(73, 6'b111111, S7, 1'b1);
        expectAt(77, 6'b111111, S0, 1'b1);
`else
        expectAt(73, 6'b111110, S7, 1'b1);
        expectAt(77, 6'b111101, S0, 1'b1);
`endif
        expectAt(81,  6'b111011, S5,  1'b1);
        expectAt(97,  6'b111110, S7,  1'b1);
        expectAt(109, 6'b110111, S4,  1'b1);
        expectAt(110, 6'b111111, SBL, 1'b1);
        expectAt(111, 6'b111111, SBL, 1'b1);
        waitEdges(41);

        // Reset mid-slot at digit 3, between clock edges
        @(posedge CP);
        #2;
        reset = 1'b1;
        @(negedge CP);
        #2;
        waitEdges(1);
        reset = 1'b0;
        base  = cyc;
        expectAt(1, 6'b111110, S7, 1'b1);
        expectAt(4, 6'b111110, S7, 1'b1);
        expectAt(5, 6'b111101, S0, 1'b1);
        waitEdges(8);

        for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge CP);
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan6.md
# seg_scan6

Six-digit multiplexed seven-segment display driver for the clock; sits directly downstream of the hour, minute and second counters. Time-multiplexes BCD hour/minute/second values onto one shared segment bus with per-digit anode enables. Shows the AM/PM flag on the hour-units decimal point. Blanks the field being set at a visible rate.

## Interface
Parameters:
- SCAN_DIV, 50000: CP cycles per digit slot; legal range ≥1.
- BLINK_HALF, 83: full scan frames (6 slots each) per blink half-period; legal range ≥1.

Ports:
- CP  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- hour  input  6  BCD hour; [5:4] tens, [3:0] units (12h or 24h value as produced upstream).
- min  input  7  BCD minute; [6:4] tens, [3:0] units.
- sec  input  7  BCD second; [6:4] tens, [3:0] units.
- noon  input  1  1 = PM; lights the decimal point on the hour-units digit.
- setSel  input  2  field under adjustment: 00 none, 01 hour, 10 minute, 11 second.
- an  output  6  active-low digit enables; an[0] = sec units … an[5] = hour tens.
- seg  output  7  active-low segments; seg[6:0] = g,f,e,d,c,b,a.
- dp  output  1  active-low decimal point.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. It generates a slot tick on the cycle it equals SCAN_DIV-1.
- Digit index 0..5 advances on each slot tick. Index 5 wraps to 0; the wrap marks end of frame.
- Digit map: 0 sec[3:0], 1 sec[6:4], 2 min[3:0], 3 min[6:4], 4 hour[3:0], 5 hour[5:4].
- Exactly one an bit is low while a digit is shown: an[index]. All other an bits stay high.
- Segment decode: values 0..9 use the standard patterns. Any value >9 drives blank segments (all 1), and its an stays asserted.
- Leading-zero blanking: when index 5 and hour[5:4]==0, an[5] is deasserted (all an high).
- dp is low only when index==4 and noon==1. Otherwise dp is 1.
- Inputs are sampled combinationally each cycle and are not latched per frame. Mid-frame input changes appear on the next registered update.

## Timing
- an, seg and dp are registered. They reflect the index and inputs of the previous cycle, so latency is 1 CP cycle.
- Reset values: prescaler 0, index 0, blink frame counter 0, blink phase 0 (visible), an=6'b111111, seg=7'b1111111, dp=1.
- First rising edge after reset release drives digit 0 (sec units).
- Digit 1 follows SCAN_DIV cycles later.
- Full frame period = 6×SCAN_DIV cycles.
- SCAN_DIV=1: index advances every cycle.
- Reset asserted mid-slot or mid-frame: all outputs return to the reset values asynchronously. Scanning restarts at digit 0 and the blink phase restarts at visible.
- Index change and blink toggle on the same tick: both take effect in the same registered update.

## Configuration
- SEG_BLINK_EN defined:
  - A frame counter counts end-of-frame events 0..BLINK_HALF-1 and toggles blink phase on wrap.
  - When phase==1 and setSel selects a field, both digits of that field have their an deasserted.
  - setSel 01 blanks digits 4–5, 10 blanks digits 2–3, 11 blanks digits 0–1.
  - dp is also suppressed while digit 4 is blanked.
  - setSel change takes effect on the next cycle without resetting the phase.
- SEG_BLINK_EN undefined:
  - setSel is ignored and no blink logic is synthesised.
  - All digits are always shown per the Operation rules.

## Structure
- Shared package clock_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (active-low, g..a order);
  - digit index constants DIG_SEC_U..DIG_HOUR_T;
  - setSel encodings SEL_NONE, SEL_HOUR, SEL_MIN, SEL_SEC.
- One sub-module, bcd7seg: a combinational 4-bit BCD to active-low 7-segment decoder that outputs blank for values >9.
- Prescaler, index, blink counter and output registers live in seg_scan6.

## Test plan
Common settings: SCAN_DIV=4, BLINK_HALF=2, SEG_BLINK_EN defined unless stated.

- Reset held, then released with hour=6'h23, min=7'h45, sec=7'h07, noon=0 → during reset an=111111, seg=1111111, dp=1. First edge after release: an=111110, seg=SEG_7. After 4 more cycles: an=111101, seg=SEG_0.
- Same inputs, run 24 cycles → an sequence 0..5 each held 4 cycles. Hour tens shows SEG_2 and hour units shows SEG_3. The sequence wraps to an=111110 at cycle 25.
- hour=6'h05, noon=1 → digit 5 slot has an=111111 (leading zero blanked). Digit 4 slot has seg=SEG_5 and dp=0.
- min=7'h4C → digit 2 slot has an=111011 and seg=1111111.
- setSel=10 → frames 0–1 show minutes and frames 2–3 have an[3:2] held high. Other digits are unaffected.
- Rebuild without SEG_BLINK_EN and repeat the previous case → minutes visible in every frame.
- Assert reset mid-slot at digit 3 → outputs go to the reset values with no clock edge. After release, scanning restarts at an=111110.
